// File: rtl/apple2_disk_ii_stepper.sv
// rtl/apple2_disk_ii_stepper.sv - Disk II slot controller: boot ROM, stepper, motor spin-down, track buffer
// Byte i of the slot ROM image lives at IMAGE[8*i +: 8].
module apple2_disk_iirom #(
  parameter logic [2047:0] IMAGE = '0
) (
  input  logic       clk_i,
  input  logic [7:0] addr_i,
  output logic [7:0] data_o
);
  always_ff @(posedge clk_i) data_o <= IMAGE[{addr_i, 3'b000} +: 8];
endmodule

module apple2_disk_ii_stepper #(
  parameter int              TRACK_BYTES      = 6656,
  parameter int              ADDR_W           = 14,
  parameter int              BYTE_CYCLES      = 32,
  parameter int              MAX_PHASE        = 139,
  parameter int              MOTOR_OFF_CYCLES = 2000000,
  parameter logic [2047:0]   ROM_IMAGE        = '0
) (
  input  logic              clk_2m,
  input  logic              reset_n,
  input  logic              pre_phase_zero,
  input  logic              io_select,
  input  logic              device_select,
  input  logic [15:0]       a,
  input  logic [7:0]        d_in,
  output logic [7:0]        d_out,
  input  logic [1:0]        write_protect,
  output logic [5:0]        track,
  output logic              track_changed,
  output logic [ADDR_W-1:0] head_addr,
  output logic              track_dirty,
  output logic              d1_active,
  output logic              d2_active,
  input  logic [ADDR_W-1:0] ram_addr,
  input  logic [7:0]        ram_di,
  input  logic              ram_we,
  output logic [7:0]        ram_do
);
  localparam int TMR_W  = (BYTE_CYCLES > 2) ? $clog2(BYTE_CYCLES) : 1;
  localparam int SPIN_W = (MOTOR_OFF_CYCLES > 0) ? $clog2(MOTOR_OFF_CYCLES + 1) : 1;
  localparam int IDX_W  = (TRACK_BYTES > 1) ? $clog2(TRACK_BYTES) : 1;
  localparam logic [TMR_W-1:0]  TMR_RELOAD = TMR_W'(BYTE_CYCLES - 1);
  localparam logic [SPIN_W-1:0] SPIN_LOAD  = SPIN_W'(MOTOR_OFF_CYCLES);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(TRACK_BYTES - 1);
  localparam logic [7:0]        MAX_PH     = 8'(MAX_PHASE);

  logic [7:0]        mem [TRACK_BYTES];
  logic [7:0]        phase_q, phase_d;
  logic [3:0]        mag_q, mag_d;
  logic              eval_q, eval_d, tchg_q, tchg_d;
  logic              running_q, running_d;
  logic [SPIN_W-1:0] spin_q, spin_d;
  logic              drive_q, drive_d, q6_q, q6_d, q7_q, q7_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [ADDR_W-1:0] head_q, head_d, head_next;
  logic [7:0]        latch_q, wlatch_q, wlatch_d, ram_do_q, rom_data;
  logic              valid_q, valid_d, dirty_q, dirty_d;
  logic              strobe, sel_wp, expire, store, load_latch;
  logic [8:0]        ph_up;
  logic [1:0]        c_up, c_dn;
  logic              unused_bits;

  apple2_disk_iirom #(.IMAGE(ROM_IMAGE)) u_rom (
    .clk_i  (clk_2m),
    .addr_i (a[7:0]),
    .data_o (rom_data)
  );

  assign strobe      = pre_phase_zero & device_select;
  assign sel_wp      = write_protect[drive_q];
  assign expire      = running_q && (tmr_q == '0);
  assign head_next   = (head_q == LAST_ADDR) ? '0 : head_q + 1'b1;
  assign store       = expire & q7_q & ~sel_wp;
  assign load_latch  = expire & ~q7_q;
  assign unused_bits = ^{a[15:8], ram_addr, head_q};

  always_comb begin
    phase_d   = phase_q;
    mag_d     = mag_q;
    eval_d    = 1'b0;
    tchg_d    = 1'b0;
    running_d = running_q;
    spin_d    = spin_q;
    drive_d   = drive_q;
    q6_d      = q6_q;
    q7_d      = q7_q;
    tmr_d     = tmr_q;
    head_d    = head_q;
    valid_d   = valid_q;
    wlatch_d  = wlatch_q;
    dirty_d   = dirty_q;
    ph_up     = {1'b0, phase_q} + 9'd2;
    c_up      = phase_q[2:1] + 2'd1;
    c_dn      = phase_q[2:1] - 2'd1;

    if (spin_q != '0) begin
      spin_d = spin_q - 1'b1;
      if (spin_q == SPIN_W'(1)) running_d = 1'b0;
    end

    if (strobe) begin
      if (!a[3]) begin
        mag_d[a[2:1]] = a[0];
        eval_d        = 1'b1;
      end else begin
        case (a[2:1])
          2'b00: begin
            if (a[0]) begin
              running_d = 1'b1;
              spin_d    = '0;
            end else if (running_q && spin_q == '0) begin
              spin_d = SPIN_LOAD;
              if (MOTOR_OFF_CYCLES == 0) running_d = 1'b0;
            end
          end
          2'b01:   drive_d = a[0];
          2'b10:   q6_d    = a[0];
          default: q7_d    = a[0];
        endcase
        if (a[2:0] == 3'b101 && q6_q && q7_q) wlatch_d = d_in;
        if (a[2:0] == 3'b100 && !q6_q && !q7_q) valid_d = 1'b0;
      end
    end

    // Magnets are sampled one cycle after the write so back-to-back switch hits settle first.
    if (eval_q) begin
      if (mag_q[c_up] && !mag_q[c_dn])
        phase_d = (ph_up > {1'b0, MAX_PH}) ? MAX_PH : ph_up[7:0];
      else if (mag_q[c_dn] && !mag_q[c_up])
        phase_d = (phase_q < 8'd2) ? 8'd0 : phase_q - 8'd2;
      tchg_d = (phase_d[7:2] != phase_q[7:2]);
    end

    if (running_q) begin
      if (expire) begin
        tmr_d  = TMR_RELOAD;
        head_d = head_next;
        if (!q7_q) valid_d = 1'b1;
      end else begin
        tmr_d = tmr_q - 1'b1;
      end
    end

    if (ram_we) dirty_d = 1'b0;
    if (store)  dirty_d = 1'b1;
  end

  always_ff @(posedge clk_2m or negedge reset_n) begin
    if (!reset_n) begin
      phase_q   <= 8'd70;
      mag_q     <= '0;
      eval_q    <= 1'b0;
      tchg_q    <= 1'b0;
      running_q <= 1'b0;
      spin_q    <= '0;
      drive_q   <= 1'b0;
      q6_q      <= 1'b0;
      q7_q      <= 1'b0;
      tmr_q     <= TMR_RELOAD;
      head_q    <= '0;
      latch_q   <= '0;
      valid_q   <= 1'b0;
      wlatch_q  <= '0;
      dirty_q   <= 1'b0;
      ram_do_q  <= '0;
    end else begin
      phase_q   <= phase_d;
      mag_q     <= mag_d;
      eval_q    <= eval_d;
      tchg_q    <= tchg_d;
      running_q <= running_d;
      spin_q    <= spin_d;
      drive_q   <= drive_d;
      q6_q      <= q6_d;
      q7_q      <= q7_d;
      tmr_q     <= tmr_d;
      head_q    <= head_d;
      valid_q   <= valid_d;
      wlatch_q  <= wlatch_d;
      dirty_q   <= dirty_d;
      if (load_latch) latch_q <= mem[head_next[IDX_W-1:0]];
      ram_do_q  <= mem[ram_addr[IDX_W-1:0]];
    end
  end

  // Buffer has no reset so its contents survive a controller reset; the controller store wins the port.
  always_ff @(posedge clk_2m) begin
    if (store)       mem[head_q[IDX_W-1:0]]   <= wlatch_q;
    else if (ram_we) mem[ram_addr[IDX_W-1:0]] <= ram_di;
  end

  always_comb begin
    d_out = 8'h00;
    if (io_select)
      d_out = rom_data;
    else if (device_select) begin
      if (a[3:0] == 4'hC && !q6_q && !q7_q)
        d_out = {latch_q[7] & valid_q, latch_q[6:0]};
      else if (a[3:0] == 4'hD && q6_q && !q7_q)
        d_out = {sel_wp, 7'b0};
    end
  end

  assign track         = phase_q[7:2];
  assign track_changed = tchg_q;
  assign head_addr     = head_q;
  assign track_dirty   = dirty_q;
  assign d1_active     = running_q & ~drive_q;
  assign d2_active     = running_q & drive_q;
  assign ram_do        = ram_do_q;
endmodule

// File: tb/tb_apple2_disk_ii_stepper.sv
// tb/tb_apple2_disk_ii_stepper.sv - directed self-checking bench for apple2_disk_ii_stepper
module tb_apple2_disk_ii_stepper;
  localparam int TB_BYTES = 20;
  localparam int TB_AW    = 5;

  function automatic logic [2047:0] mk_rom();
    logic [2047:0] r;
    for (int i = 0; i < 256; i++) r[8*i +: 8] = 8'(i) ^ 8'hA5;
    return r;
  endfunction
  localparam logic [2047:0] ROM = mk_rom();

  logic             clk = 1'b0;
  logic             reset_n, pre_phase_zero, io_select, device_select;
  logic [15:0]      a;
  logic [7:0]       d_in, d_out;
  logic [1:0]       write_protect;
  logic [5:0]       track;
  logic             track_changed, track_dirty, d1_active, d2_active;
  logic [TB_AW-1:0] head_addr, ram_addr;
  logic [7:0]       ram_di, ram_do;
  logic             ram_we;

  logic [7:0] mem_m [TB_BYTES];
  int n_checks = 0;
  int n_errors = 0;
  int pulses = 0;
  int p0, p, c;

  apple2_disk_ii_stepper #(
    .TRACK_BYTES(TB_BYTES), .ADDR_W(TB_AW), .BYTE_CYCLES(32), .MAX_PHASE(139),
    .MOTOR_OFF_CYCLES(100), .ROM_IMAGE(ROM)
  ) dut (
    .clk_2m(clk), .reset_n(reset_n), .pre_phase_zero(pre_phase_zero), .io_select(io_select),
    .device_select(device_select), .a(a), .d_in(d_in), .d_out(d_out),
    .write_protect(write_protect), .track(track), .track_changed(track_changed),
    .head_addr(head_addr), .track_dirty(track_dirty), .d1_active(d1_active),
    .d2_active(d2_active), .ram_addr(ram_addr), .ram_di(ram_di), .ram_we(ram_we), .ram_do(ram_do)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (track_changed === 1'b1) pulses++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // All stimulus tasks are entered at a negedge and return at a negedge.
  task automatic strobe(input logic [3:0] lo, input logic [7:0] din);
    a = {12'hC0E, lo}; d_in = din; device_select = 1'b1; pre_phase_zero = 1'b1;
    @(negedge clk);
    device_select = 1'b0; pre_phase_zero = 1'b0;
  endtask

  task automatic peek(input logic [3:0] lo);
    a = {12'hC0E, lo}; device_select = 1'b1; pre_phase_zero = 1'b0;
    #1;
  endtask

  task automatic host_wr(input logic [TB_AW-1:0] ad, input logic [7:0] v);
    ram_addr = ad; ram_di = v; ram_we = 1'b1;
    @(negedge clk);
    ram_we = 1'b0;
    mem_m[ad] = v;
  endtask

  task automatic host_rd(input logic [TB_AW-1:0] ad, input string tag);
    ram_addr = ad;
    @(negedge clk);
    chk(tag, ram_do, mem_m[ad]);
  endtask

  initial begin
    reset_n = 1'b0; pre_phase_zero = 1'b0; io_select = 1'b0; device_select = 1'b0;
    a = '0; d_in = '0; write_protect = 2'b00; ram_addr = '0; ram_di = '0; ram_we = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rst_track", track, 17);
    chk("rst_tchg", track_changed, 0);
    chk("rst_head", head_addr, 0);
    chk("rst_dirty", track_dirty, 0);
    chk("rst_d1", d1_active, 0);
    chk("rst_d2", d2_active, 0);
    chk("rst_ram_do", ram_do, 0);
    chk("rst_d_out", d_out, 0);

    @(negedge clk);
    io_select = 1'b1; a = 16'hC605;
    @(negedge clk);
    chk("rom_05", d_out, 8'hA0);
    a = 16'hC6FF;
    @(negedge clk);
    chk("rom_ff", d_out, 8'h5A);
    io_select = 1'b0;

    p0 = pulses;
    strobe(4'h1, 0);
    chk("step_latency", track, 17);
    @(negedge clk);
    chk("step_track", track, 18);
    chk("step_pulse", track_changed, 1);
    strobe(4'h3, 0);
    strobe(4'h6, 0);
    repeat (2) @(negedge clk);
    chk("seq_track", track, 18);
    chk("seq_pulses", pulses - p0, 1);

    strobe(4'h2, 0);
    repeat (2) @(negedge clk);
    chk("hold_track", track, 18);
    p0 = pulses;
    p = 72;
    while (p > 0) begin
      c = (p >> 1) & 3;
      strobe({1'b0, 2'((c + 3) % 4), 1'b1}, 0);
      strobe({1'b0, 2'(c), 1'b0}, 0);
      p -= 2;
    end
    repeat (2) @(negedge clk);
    chk("sweep_track", track, 0);
    chk("sweep_pulses", pulses - p0, 18);
    p0 = pulses;
    strobe(4'h7, 0);
    repeat (2) @(negedge clk);
    chk("sat_track", track, 0);
    chk("sat_pulses", pulses - p0, 0);

    for (int i = 0; i < TB_BYTES; i++) host_wr(TB_AW'(i), 8'h80 | 8'(i * 5));
    host_rd(5'd3, "ram_do_rd");

    strobe(4'h9, 0);
    chk("mon_d1", d1_active, 1);
    chk("mon_d2", d2_active, 0);
    repeat (31) @(negedge clk);
    peek(4'hC);
    chk("pre_expiry_dout", d_out, 8'h00);
    chk("pre_expiry_head", head_addr, 0);
    @(negedge clk);
    peek(4'hC);
    chk("byte1_head", head_addr, 1);
    chk("byte1_dout", d_out, mem_m[1]);
    strobe(4'hC, 0);
    peek(4'hC);
    chk("reread_bit7", d_out, mem_m[1] & 8'h7F);
    device_select = 1'b0;
    repeat (31) @(negedge clk);
    for (int k = 2; k <= 21; k++) begin
      peek(4'hC);
      chk("rd_head", head_addr, k % TB_BYTES);
      chk("rd_dout", d_out, mem_m[k % TB_BYTES]);
      device_select = 1'b0;
      if (k < 21) begin
        repeat (31) @(negedge clk);
        if (k == 4) strobe(4'hC, 0);
        else @(negedge clk);
      end
    end

    strobe(4'hF, 0);
    strobe(4'hD, 0);
    strobe(4'hD, 8'hD5);
    repeat (28) @(negedge clk);
    chk("wr_dirty_pre", track_dirty, 0);
    chk("wr_head_pre", head_addr, 1);
    @(negedge clk);
    chk("wr_dirty", track_dirty, 1);
    chk("wr_head", head_addr, 2);
    strobe(4'hE, 0);
    mem_m[1] = 8'hD5;
    host_rd(5'd1, "wr_buf");
    host_rd(5'd2, "wr_next_buf");
    host_wr(5'd10, 8'h33);
    chk("host_clears_dirty", track_dirty, 0);

    write_protect = 2'b01;
    peek(4'hD);
    chk("wp_sense_1", d_out, 8'h80);
    write_protect = 2'b10;
    peek(4'hD);
    chk("wp_sense_0", d_out, 8'h00);
    device_select = 1'b0;
    write_protect = 2'b01;
    strobe(4'hF, 0);
    repeat (70) @(negedge clk);
    chk("wp_dirty", track_dirty, 0);
    strobe(4'hE, 0);

    strobe(4'hB, 0);
    chk("drv2_d2", d2_active, 1);
    chk("drv2_d1", d1_active, 0);
    strobe(4'hA, 0);
    chk("drv1_d1", d1_active, 1);

    strobe(4'h8, 0);
    repeat (99) @(negedge clk);
    chk("spin_hold", d1_active, 1);
    @(negedge clk);
    chk("spin_drop", d1_active, 0);
    strobe(4'h9, 0);
    strobe(4'h8, 0);
    repeat (49) @(negedge clk);
    strobe(4'h9, 0);
    repeat (150) @(negedge clk);
    chk("spin_cancel", d1_active, 1);

    #2 reset_n = 1'b0;
    #1;
    chk("arst_track", track, 17);
    chk("arst_head", head_addr, 0);
    chk("arst_d1", d1_active, 0);
    chk("arst_tchg", track_changed, 0);
    chk("arst_ram_do", ram_do, 0);
    chk("arst_dirty", track_dirty, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < TB_BYTES; i++) host_rd(TB_AW'(i), "buf_keep");
    chk("post_rst_head", head_addr, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/apple2_disk_ii_stepper.md
# apple2_disk_ii_stepper

Next-generation Disk II slot controller for the Apple II platform. It decodes the slot I/O space and returns the boot ROM, and drives a real head-stepper model from the four magnet phases. It adds a motor spin-down timer, byte-timed read with a data-valid bit, and a write path into a parametrised track buffer. The host loads and reads back the track buffer through a side port; a dirty flag and a track-change pulse tell the host when to swap the buffer.

## Interface
- TRACK_BYTES, 6656, bytes per track buffer; head address wraps at TRACK_BYTES-1
- ADDR_W, 14, track-buffer address width; must satisfy 2^ADDR_W >= TRACK_BYTES
- BYTE_CYCLES, 32, clk_2m cycles per disk byte; minimum 4
- MAX_PHASE, 139, highest quarter-track head position
- MOTOR_OFF_CYCLES, 2000000, spin-down delay after motor-off switch
- clk_2m  in  1  sole clock; all state updates on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- pre_phase_zero  in  1  bus access strobe; soft switches act only when it is high
- io_select  in  1  slot ROM space ($CnXX) select
- device_select  in  1  slot I/O space ($C0nX) select
- a  in  16  CPU address
- d_in  in  8  CPU write data
- d_out  out  8  CPU read data; combinational
- write_protect  in  2  per-drive write-protect sense
- track  out  6  current track, equal to phase[7:2]
- track_changed  out  1  one-cycle pulse when track changes
- head_addr  out  ADDR_W  current byte position in the track buffer
- track_dirty  out  1  buffer modified by the CPU since the last host load
- d1_active, d2_active  out  1 each  motor running with drive 1 / drive 2 selected
- ram_addr  in  ADDR_W  host-port address
- ram_di  in  8  host-port write data
- ram_we  in  1  host-port write enable
- ram_do  out  8  host-port read data, registered

## Operation
- The slot ROM (apple2_disk_iirom, clocked by clk_2m) is addressed by a[7:0]. d_out returns ROM data when io_select is high.
- A soft switch fires on strobe = pre_phase_zero & device_select.
  - a[3]=0: magnet a[2:1] is set to a[0].
  - a[3:1]=100: motor switch.
  - 101: drive select.
  - 110: Q6.
  - 111: Q7.
- Stepper. Let c = phase[2:1].
  - One cycle after any magnet write, evaluate the magnets. Magnet (c+1)%4 on and (c-1)%4 off: phase += 2, saturating at MAX_PHASE. Magnet (c-1)%4 on and (c+1)%4 off: phase -= 2, saturating at 0. Otherwise phase holds.
  - If track differs after the update, pulse track_changed for one cycle.
- Motor.
  - Switch on: running = 1 immediately and the spin-down counter is cleared.
  - Switch off: the counter loads MOTOR_OFF_CYCLES; running drops when it reaches 0.
  - A switch-on during spin-down cancels the spin-down.
- Byte timer counts only while running. On expiry it reloads BYTE_CYCLES-1.
  - Read mode (Q7=0): head_addr advances, wrapping to 0. The latch loads the buffer byte at the new address and valid is set to 1.
  - Write mode (Q7=1): the write latch is stored at head_addr, head_addr then advances, and track_dirty is set to 1. The latch is not reloaded.
- CPU data reads, decoded with device_select:
  - $C0nC with Q6=0, Q7=0: d_out = {latch[7]&valid, latch[6:0]}. A strobe on this access clears valid at the end of the cycle.
  - $C0nD with Q6=1, Q7=0: d_out = {write_protect[selected drive], 7'b0}.
  - Any other address: d_out = 0.
- CPU write: a strobe to $C0nD with Q6=1 and Q7=1 loads the write latch from d_in.
- The write path is disabled when the selected drive's write_protect is 1. In that case no store happens and dirty is not set.
- Host port.
  - ram_we writes ram_di to ram_addr and clears track_dirty.
  - ram_do = buffer[ram_addr], registered.
  - If a controller store and ram_we occur in the same cycle, the controller store wins and the host write is dropped.

## Timing
- Reset values:
  - phase = 70, track = 17.
  - Magnets, motor, drive select, Q6, Q7 = 0.
  - head_addr = 0, byte timer = BYTE_CYCLES-1.
  - Latch and write latch = 0, valid = 0.
  - track_dirty = 0, track_changed = 0, d1/d2_active = 0, ram_do = 0.
- Reset asserted mid-write aborts any pending store. The buffer contents are not cleared.
- Soft-switch effects are visible on the cycle after the strobe. A head step appears 2 cycles after the magnet strobe.
- Read path: the latch is valid 1 cycle after timer expiry. Byte period is exactly BYTE_CYCLES cycles.
- Valid-clear and a latch reload in the same cycle: the reload wins and valid stays 1.
- Motor off at the same time as a timer expiry: the expiry still completes. The timer stops once running = 0.

## Test plan
- Reset, then magnet sequence on 0,1 (c=3→0 region), off 3: phase 70→72, track 18, one track_changed pulse. From phase 0, stepping outward saturates at 0 with no pulse.
- Host loads 0x00..0x07 at addresses 0..7, motor on, read $C0nC repeatedly: bytes 0x00..0x07 appear every 32 cycles. A second read of the same byte returns bit7 = 0. Address 6655 wraps to 0.
- Q6=Q7=1, write 0xD5 to $C0nD, wait for one byte period: buffer[head_addr] = 0xD5 (read back via ram_do) and track_dirty = 1. A subsequent ram_we clears track_dirty.
- With write_protect[0]=1: $C0nD in sense mode returns 0x80, and a write-mode byte period leaves the buffer and dirty unchanged.
- Motor off with MOTOR_OFF_CYCLES=100: d1_active stays 1 for 100 cycles, then 0. Motor on at cycle 50 keeps it at 1 indefinitely.
- reset_n pulsed low mid-transfer: all outputs return to reset values asynchronously, and buffer contents are preserved.
